// File: rtl/mc_controller_ws.sv
// Multicycle MIPS control unit with parametrised memory wait states, optional
// MemReady handshake, a sticky ILLEGAL halt state and a retired-instruction counter.
module mc_controller_ws #(
  parameter int MEM_WAIT  = 0,
  parameter int USE_READY = 0,
  parameter int CNT_W     = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             MemReq,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemToReg,
  output logic             ALUSrcA,
  output logic             RegWrite,
  output logic             PCEn,
  output logic             ExtOp,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSrc,
  output logic [2:0]       AluCtl,
  output logic [3:0]       Stat,
  output logic             Halt,
  output logic             InstrDone,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_REX     = 4'd6,
    S_RWB     = 4'd7,
    S_BEX     = 4'd8,
    S_IEX     = 4'd9,
    S_IWB     = 4'd10,
    S_JEX     = 4'd11,
    S_ILLEGAL = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0]       WAIT_MAX = 4'(MEM_WAIT);
  localparam logic             READY_EN = (USE_READY != 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // R-type decode: {legal, alu control}
  function automatic logic [3:0] rtype_dec(input logic [5:0] funct);
    case (funct)
      6'b100000: rtype_dec = {1'b1, 3'b010};
      6'b100010: rtype_dec = {1'b1, 3'b110};
      6'b100100: rtype_dec = {1'b1, 3'b000};
      6'b100101: rtype_dec = {1'b1, 3'b001};
      6'b101010: rtype_dec = {1'b1, 3'b111};
      default:   rtype_dec = {1'b0, 3'b010};
    endcase
  endfunction

  function automatic logic [2:0] imm_alu(input logic [5:0] op);
    case (op)
      OP_ADDI: imm_alu = 3'b010;
      OP_ANDI: imm_alu = 3'b000;
      OP_ORI:  imm_alu = 3'b001;
      OP_SLTI: imm_alu = 3'b111;
      default: imm_alu = 3'b010;
    endcase
  endfunction

  state_t           state_r;
  state_t           next_state_s;
  logic [3:0]       wcnt_r;
  logic [CNT_W-1:0] count_r;
  logic [3:0]       rtype_s;
  logic             mem_state_s;
  logic             done_s;
  logic             retire_s;
  logic             pc_write_s;
  logic             branch_s;
  logic             mem_req_s;
  logic             ir_write_s;
  logic             reg_write_s;
  logic             mem_write_s;

  assign rtype_s     = rtype_dec(Funct);
  assign mem_state_s = (state_r == S_FETCH) || (state_r == S_MEMRD) || (state_r == S_MEMWR);
  assign done_s      = (wcnt_r == WAIT_MAX) && (!READY_EN || MemReady);

  // State, memory wait counter and retired-instruction counter
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r <= S_FETCH;
      wcnt_r  <= 4'd0;
      count_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      // Counter saturates at WAIT_MAX while waiting for MemReady
      if (mem_state_s && !done_s && (wcnt_r < WAIT_MAX)) begin
        wcnt_r <= wcnt_r + 4'd1;
      end else if (mem_state_s && !done_s) begin
        wcnt_r <= wcnt_r;
      end else begin
        wcnt_r <= 4'd0;
      end
      if (retire_s) begin
        count_r <= count_r + CNT_ONE;
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Next-state and per-state datapath controls
  always_comb begin
    next_state_s = state_r;
    mem_req_s    = 1'b0;
    IorD         = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    RegDst       = 1'b0;
    MemToReg     = 1'b0;
    ALUSrcA      = 1'b0;
    reg_write_s  = 1'b0;
    pc_write_s   = 1'b0;
    branch_s     = 1'b0;
    ExtOp        = 1'b1;
    ALUSrcB      = 2'b00;
    PCSrc        = 2'b00;
    AluCtl       = 3'b010;
    Halt         = 1'b0;
    retire_s     = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_req_s = 1'b1;
        ALUSrcB   = 2'b01;
        if (done_s) begin
          ir_write_s   = 1'b1;
          pc_write_s   = 1'b1;
          next_state_s = S_DECODE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW:                       next_state_s = S_MEMADR;
          OP_BEQ, OP_BNE:                     next_state_s = S_BEX;
          OP_J:                               next_state_s = S_JEX;
          OP_RTYPE:                           next_state_s = rtype_s[3] ? S_REX : S_ILLEGAL;
          OP_ADDI, OP_ANDI, OP_SLTI, OP_ORI:  next_state_s = S_IEX;
          default:                            next_state_s = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (Op == OP_LW) begin
          next_state_s = S_MEMRD;
        end else begin
          next_state_s = S_MEMWR;
        end
      end
      S_MEMRD: begin
        mem_req_s = 1'b1;
        IorD      = 1'b1;
        if (done_s) begin
          next_state_s = S_MEMWB;
        end else begin
          next_state_s = S_MEMRD;
        end
      end
      S_MEMWR: begin
        mem_req_s   = 1'b1;
        IorD        = 1'b1;
        mem_write_s = 1'b1;
        if (done_s) begin
          retire_s     = 1'b1;
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEMWR;
        end
      end
      S_MEMWB: begin
        reg_write_s  = 1'b1;
        MemToReg     = 1'b1;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_REX: begin
        ALUSrcA      = 1'b1;
        AluCtl       = rtype_s[2:0];
        next_state_s = S_RWB;
      end
      S_RWB: begin
        reg_write_s  = 1'b1;
        RegDst       = 1'b1;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_IEX: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b10;
        AluCtl       = imm_alu(Op);
        ExtOp        = ((Op == OP_ANDI) || (Op == OP_ORI)) ? 1'b0 : 1'b1;
        next_state_s = S_IWB;
      end
      S_IWB: begin
        reg_write_s  = 1'b1;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_JEX: begin
        pc_write_s   = 1'b1;
        PCSrc        = 2'b10;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_BEX: begin
        ALUSrcA      = 1'b1;
        PCSrc        = 2'b01;
        AluCtl       = 3'b110;
        branch_s     = 1'b1;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_ILLEGAL: begin
        Halt         = 1'b1;
        next_state_s = S_ILLEGAL;
      end
      default: begin
        Halt         = 1'b1;
        next_state_s = S_ILLEGAL;
      end
    endcase
  end

  // Op[0] distinguishes BNE from BEQ
  assign PCEn       = (pc_write_s | (branch_s & (Zero ^ Op[0]))) & ~Reset;
  assign MemReq     = mem_req_s & ~Reset;
  assign MemWrite   = mem_write_s & ~Reset;
  assign IRWrite    = ir_write_s & ~Reset;
  assign RegWrite   = reg_write_s & ~Reset;
  assign InstrDone  = retire_s & ~Reset;
  assign Stat       = state_r;
  assign InstrCount = count_r;

endmodule

// File: tb/tb_mc_controller_ws.sv
// Directed self-checking bench for mc_controller_ws across four parameter sets.
module tb_mc_controller_ws;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_ADD   = 6'b100000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Group 1 drives instances a (CNT_W=32) and d (CNT_W=4), both single-cycle memory
  logic       reset1 = 1'b1;
  logic [5:0] op1 = 6'd0, funct1 = 6'd0;
  logic       zero1 = 1'b0, ready1 = 1'b0;
  // Group 2 drives instances b (MEM_WAIT=2, ready) and c (MEM_WAIT=3)
  logic       reset_b = 1'b1, reset_c = 1'b1;
  logic [5:0] op2 = 6'd0, funct2 = 6'd0;
  logic       zero2 = 1'b0, ready2 = 1'b0;

  logic a_memreq, a_iord, a_memwrite, a_irwrite, a_regdst, a_memtoreg, a_alusrca, a_regwrite, a_pcen, a_extop, a_halt, a_done;
  logic [1:0] a_alusrcb, a_pcsrc;
  logic [2:0] a_aluctl;
  logic [3:0] a_stat;
  logic [31:0] a_count;
  logic d_memreq, d_iord, d_memwrite, d_irwrite, d_regdst, d_memtoreg, d_alusrca, d_regwrite, d_pcen, d_extop, d_halt, d_done;
  logic [1:0] d_alusrcb, d_pcsrc;
  logic [2:0] d_aluctl;
  logic [3:0] d_stat;
  logic [3:0] d_count;
  logic b_memreq, b_iord, b_memwrite, b_irwrite, b_regdst, b_memtoreg, b_alusrca, b_regwrite, b_pcen, b_extop, b_halt, b_done;
  logic [1:0] b_alusrcb, b_pcsrc;
  logic [2:0] b_aluctl;
  logic [3:0] b_stat;
  logic [31:0] b_count;
  logic c_memreq, c_iord, c_memwrite, c_irwrite, c_regdst, c_memtoreg, c_alusrca, c_regwrite, c_pcen, c_extop, c_halt, c_done;
  logic [1:0] c_alusrcb, c_pcsrc;
  logic [2:0] c_aluctl;
  logic [3:0] c_stat;
  logic [31:0] c_count;

  logic [5:0] a_en, c_en;
  assign a_en = {a_pcen, a_irwrite, a_regwrite, a_memwrite, a_memreq, a_done};
  assign c_en = {c_pcen, c_irwrite, c_regwrite, c_memwrite, c_memreq, c_done};

  mc_controller_ws #(.MEM_WAIT(0), .USE_READY(0), .CNT_W(32)) dut_a (
    .CLK(clk), .Reset(reset1), .Op(op1), .Funct(funct1), .Zero(zero1), .MemReady(ready1),
    .MemReq(a_memreq), .IorD(a_iord), .MemWrite(a_memwrite), .IRWrite(a_irwrite), .RegDst(a_regdst),
    .MemToReg(a_memtoreg), .ALUSrcA(a_alusrca), .RegWrite(a_regwrite), .PCEn(a_pcen), .ExtOp(a_extop),
    .ALUSrcB(a_alusrcb), .PCSrc(a_pcsrc), .AluCtl(a_aluctl), .Stat(a_stat), .Halt(a_halt),
    .InstrDone(a_done), .InstrCount(a_count));

  mc_controller_ws #(.MEM_WAIT(0), .USE_READY(0), .CNT_W(4)) dut_d (
    .CLK(clk), .Reset(reset1), .Op(op1), .Funct(funct1), .Zero(zero1), .MemReady(ready1),
    .MemReq(d_memreq), .IorD(d_iord), .MemWrite(d_memwrite), .IRWrite(d_irwrite), .RegDst(d_regdst),
    .MemToReg(d_memtoreg), .ALUSrcA(d_alusrca), .RegWrite(d_regwrite), .PCEn(d_pcen), .ExtOp(d_extop),
    .ALUSrcB(d_alusrcb), .PCSrc(d_pcsrc), .AluCtl(d_aluctl), .Stat(d_stat), .Halt(d_halt),
    .InstrDone(d_done), .InstrCount(d_count));

  mc_controller_ws #(.MEM_WAIT(2), .USE_READY(1), .CNT_W(32)) dut_b (
    .CLK(clk), .Reset(reset_b), .Op(op2), .Funct(funct2), .Zero(zero2), .MemReady(ready2),
    .MemReq(b_memreq), .IorD(b_iord), .MemWrite(b_memwrite), .IRWrite(b_irwrite), .RegDst(b_regdst),
    .MemToReg(b_memtoreg), .ALUSrcA(b_alusrca), .RegWrite(b_regwrite), .PCEn(b_pcen), .ExtOp(b_extop),
    .ALUSrcB(b_alusrcb), .PCSrc(b_pcsrc), .AluCtl(b_aluctl), .Stat(b_stat), .Halt(b_halt),
    .InstrDone(b_done), .InstrCount(b_count));

  mc_controller_ws #(.MEM_WAIT(3), .USE_READY(0), .CNT_W(32)) dut_c (
    .CLK(clk), .Reset(reset_c), .Op(op2), .Funct(funct2), .Zero(zero2), .MemReady(ready2),
    .MemReq(c_memreq), .IorD(c_iord), .MemWrite(c_memwrite), .IRWrite(c_irwrite), .RegDst(c_regdst),
    .MemToReg(c_memtoreg), .ALUSrcA(c_alusrca), .RegWrite(c_regwrite), .PCEn(c_pcen), .ExtOp(c_extop),
    .ALUSrcB(c_alusrcb), .PCSrc(c_pcsrc), .AluCtl(c_aluctl), .Stat(c_stat), .Halt(c_halt),
    .InstrDone(c_done), .InstrCount(c_count));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One instruction on instance a; seq lists expected Stat per cycle, first nibble at MSB.
  // Execute-cycle (index 2) controls are checked against alu/ext/pcen/pcsrc.
  task automatic run1(input string tag, input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input int n, input logic [19:0] seq, input logic [2:0] alu, input logic ext,
                      input logic pcen, input logic [1:0] pcsrc);
    op1 = op;
    funct1 = fn;
    zero1 = z;
    for (int i = 0; i < n; i++) begin
      #1;
      chk({tag, "_stat"}, 32'(a_stat), 32'(seq[(4 - i) * 4 +: 4]));
      chk({tag, "_done"}, 32'(a_done), 32'(i == n - 1));
      if (i == 0) begin
        chk({tag, "_fetch_pcen_ir"}, {30'd0, a_pcen, a_irwrite}, 32'd3);
      end
      if (i == 2) begin
        chk({tag, "_aluctl"}, 32'(a_aluctl), 32'(alu));
        chk({tag, "_extop"}, 32'(a_extop), 32'(ext));
        chk({tag, "_pcen"}, 32'(a_pcen), 32'(pcen));
        chk({tag, "_pcsrc"}, 32'(a_pcsrc), 32'(pcsrc));
      end
      tick();
    end
  endtask

  logic [5:0] fn_tab [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100000, 6'b100010, 6'b100100};
  logic [2:0] alu_tab [8] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010, 3'b110, 3'b000};

  initial begin
    tick();
    tick();
    #1;
    chk("rst_stat", 32'(a_stat), 32'd0);
    chk("rst_enables", 32'(a_en), 32'd0);
    chk("rst_count", a_count, 32'd0);
    chk("rst_halt", 32'(a_halt), 32'd0);
    reset1 = 1'b0;
    #1;
    chk("fetch_memreq", 32'(a_memreq), 32'd1);

    run1("lw",  OP_LW,    6'd0,   1'b0, 5, 20'h01234, 3'b010, 1'b1, 1'b0, 2'b00);
    run1("sw",  OP_SW,    6'd0,   1'b0, 4, 20'h01250, 3'b010, 1'b1, 1'b0, 2'b00);
    run1("add", OP_RTYPE, FN_ADD, 1'b0, 4, 20'h01670, 3'b010, 1'b1, 1'b0, 2'b00);
    run1("ori", OP_ORI,   6'd0,   1'b0, 4, 20'h019A0, 3'b001, 1'b0, 1'b0, 2'b00);
    run1("beq_z1", OP_BEQ, 6'd0,  1'b1, 3, 20'h01800, 3'b110, 1'b1, 1'b1, 2'b01);
    run1("j",   OP_J,     6'd0,   1'b0, 3, 20'h01B00, 3'b010, 1'b1, 1'b1, 2'b10);
    chk("count_after6", a_count, 32'd6);
    chk("count4_after6", 32'(d_count), 32'd6);
    run1("bne_z1", OP_BNE, 6'd0,  1'b1, 3, 20'h01800, 3'b110, 1'b1, 1'b0, 2'b01);
    run1("bne_z0", OP_BNE, 6'd0,  1'b0, 3, 20'h01800, 3'b110, 1'b1, 1'b1, 2'b01);
    for (int i = 0; i < 8; i++) begin
      run1("rtype", OP_RTYPE, fn_tab[i], 1'b0, 4, 20'h01670, alu_tab[i], 1'b1, 1'b0, 2'b00);
      if (i == 6) begin
        chk("count4_at15", 32'(d_count), 32'd15);
      end
    end
    chk("count4_wrap", 32'(d_count), 32'd0);
    chk("count_16", a_count, 32'd16);

    // Illegal opcode: sticky halt with all enables low
    op1 = 6'b111111;
    #1;
    chk("ill_fetch", 32'(a_stat), 32'd0);
    tick();
    #1;
    chk("ill_decode", 32'(a_stat), 32'd1);
    tick();
    for (int i = 0; i < 20; i++) begin
      zero1 = i[0];
      #1;
      chk("ill_stat", 32'(a_stat), 32'd15);
      chk("ill_halt", 32'(a_halt), 32'd1);
      chk("ill_enables", 32'(a_en), 32'd0);
      tick();
    end
    chk("ill_count", a_count, 32'd16);
    reset1 = 1'b1;
    tick();
    reset1 = 1'b0;
    op1 = OP_RTYPE;
    funct1 = 6'b000000;
    #1;
    chk("ill_rst_stat", 32'(a_stat), 32'd0);
    chk("ill_rst_halt", 32'(a_halt), 32'd0);
    chk("ill_rst_count", a_count, 32'd0);
    tick();
    #1;
    chk("illfn_decode", 32'(a_stat), 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("illfn_stat", 32'(a_stat), 32'd15);
      chk("illfn_halt", 32'(a_halt), 32'd1);
      tick();
    end
    reset1 = 1'b1;
    #1;
    chk("illfn_rst_enables", 32'(a_en), 32'd0);
    tick();
    reset1 = 1'b0;
    #1;
    chk("illfn_rst_stat", 32'(a_stat), 32'd0);
    chk("illfn_rst_halt", 32'(a_halt), 32'd0);

    // Wait states with MemReady handshake: FETCH held 6 cycles
    reset_b = 1'b0;
    op2 = OP_LW;
    funct2 = 6'd0;
    for (int i = 0; i < 6; i++) begin
      ready2 = (i == 5);
      #1;
      chk("ws_fetch_stat", 32'(b_stat), 32'd0);
      chk("ws_fetch_memreq", 32'(b_memreq), 32'd1);
      chk("ws_fetch_irwrite", 32'(b_irwrite), 32'(i == 5));
      chk("ws_fetch_pcen", 32'(b_pcen), 32'(i == 5));
      tick();
    end
    #1;
    chk("ws_decode", 32'(b_stat), 32'd1);
    tick();
    #1;
    chk("ws_memadr", 32'(b_stat), 32'd2);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ws_memrd", 32'(b_stat), 32'd3);
      chk("ws_memrd_iord", 32'(b_iord), 32'd1);
      tick();
    end
    #1;
    chk("ws_memwb", 32'(b_stat), 32'd4);
    chk("ws_memwb_done", 32'(b_done), 32'd1);
    tick();
    #1;
    chk("ws_count", b_count, 32'd1);

    // Reset in the middle of a waiting MEMWR
    reset_b = 1'b1;
    reset_c = 1'b0;
    op2 = OP_RTYPE;
    funct2 = FN_ADD;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mw_fetch1", 32'(c_stat), 32'd0);
      tick();
    end
    tick();
    tick();
    #1;
    chk("mw_rwb", 32'(c_stat), 32'd7);
    tick();
    op2 = OP_SW;
    #1;
    chk("mw_count1", c_count, 32'd1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mw_fetch2", 32'(c_stat), 32'd0);
      tick();
    end
    tick();
    tick();
    #1;
    chk("mw_memwr", 32'(c_stat), 32'd5);
    chk("mw_memwrite", 32'(c_memwrite), 32'd1);
    tick();
    reset_c = 1'b1;
    #1;
    chk("mw_rst_enables", 32'(c_en), 32'd0);
    chk("mw_rst_stat", 32'(c_stat), 32'd5);
    tick();
    reset_c = 1'b0;
    #1;
    chk("mw_after_stat", 32'(c_stat), 32'd0);
    chk("mw_after_count", c_count, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
